// File: rtl/fixed_point_arith.sv
// Registered unsigned Qwhole.fraction add/subtract/multiply unit.
// All three results and their flags load together one clock after calculate_en.
module fixed_point_arith #(
  parameter int wholeWidth    = 16,
  parameter int fractionWidth = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 calculate_en,
  input  logic [wholeWidth+fractionWidth-1:0]  valueOne,
  input  logic [wholeWidth+fractionWidth-1:0]  valueTwo,
  output logic [wholeWidth+fractionWidth-1:0]  addend,
  output logic [wholeWidth+fractionWidth-1:0]  difference,
  output logic [wholeWidth+fractionWidth-1:0]  product,
  output logic                                 result_valid,
  output logic                                 add_carry,
  output logic                                 sub_borrow,
  output logic                                 mul_overflow
);

  localparam int N = wholeWidth + fractionWidth;

  // Handshake: there is no ready; every calculate_en edge is accepted. result_valid
  // is high for exactly the cycle following each accepting edge, so back-to-back
  // enables keep it high continuously.

  logic [N:0]     sumFull;
  logic [N-1:0]   diffWrap;
  logic           borrowNext;
  logic [2*N-1:0] fullProduct;
  logic [N-1:0]   productAligned;
  logic           overflowNext;
  logic           unusedProdBits;

  assign sumFull        = {1'b0, valueOne} + {1'b0, valueTwo};
  assign diffWrap       = valueOne - valueTwo;
  assign borrowNext     = (valueOne < valueTwo);
  assign fullProduct    = (2*N)'(valueOne) * (2*N)'(valueTwo);

  // Dropping the low fraction bits realigns the binary point and truncates toward zero.
  assign productAligned = fullProduct[fractionWidth +: N];
  assign overflowNext   = |fullProduct[2*N-1 : N+fractionWidth];
  assign unusedProdBits = ^fullProduct[fractionWidth-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      addend       <= '0;
      difference   <= '0;
      product      <= '0;
      result_valid <= 1'b0;
      add_carry    <= 1'b0;
      sub_borrow   <= 1'b0;
      mul_overflow <= 1'b0;
    end else if (calculate_en) begin
      addend       <= sumFull[N-1:0];
      difference   <= diffWrap;
      product      <= productAligned;
      result_valid <= 1'b1;
      add_carry    <= sumFull[N];
      sub_borrow   <= borrowNext;
      mul_overflow <= overflowNext;
    end else begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_point_arith.sv
// Bench for fixed_point_arith (Q16.16): directed literal cases plus randomized
// stimulus scored every cycle against a plain-arithmetic reference model.
module tb_fixed_point_arith;

  localparam int WHOLE = 16;
  localparam int FRAC  = 16;
  localparam int N     = WHOLE + FRAC;
  localparam int W     = 3*N + 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          calculate_en = 1'b1;
  logic [N-1:0]  valueOne = '0;
  logic [N-1:0]  valueTwo = '0;
  logic [N-1:0]  addend, difference, product;
  logic          result_valid, add_carry, sub_borrow, mul_overflow;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clock = ~clock;

  fixed_point_arith #(.wholeWidth(WHOLE), .fractionWidth(FRAC)) dut (
    .clock        (clock),
    .reset        (reset),
    .calculate_en (calculate_en),
    .valueOne     (valueOne),
    .valueTwo     (valueTwo),
    .addend       (addend),
    .difference   (difference),
    .product      (product),
    .result_valid (result_valid),
    .add_carry    (add_carry),
    .sub_borrow   (sub_borrow),
    .mul_overflow (mul_overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: arithmetic on 64-bit integers, one expected vector per edge
  logic [N-1:0] mAdd = '0, mDiff = '0, mProd = '0;
  logic         mValid = 1'b0, mCarry = 1'b0, mBorrow = 1'b0, mOvf = 1'b0;

  always @(posedge clock) begin : modelProc
    longint unsigned a, b, sum, full;
    if (reset) begin
      mAdd = '0; mDiff = '0; mProd = '0;
      mValid = 1'b0; mCarry = 1'b0; mBorrow = 1'b0; mOvf = 1'b0;
    end else if (calculate_en) begin
      a       = longint'(valueOne);
      b       = longint'(valueTwo);
      sum     = a + b;
      full    = a * b;
      mAdd    = N'(sum);
      mCarry  = (sum >= (64'd1 << N));
      mDiff   = N'(a - b);
      mBorrow = (a < b);
      mProd   = N'(full >> FRAC);
      mOvf    = ((full >> (N + FRAC)) != 0);
      mValid  = 1'b1;
    end else begin
      mValid = 1'b0;
    end
    exp_q.push_back({mValid, mCarry, mBorrow, mOvf, mAdd, mDiff, mProd});
  end

  // scoreboard compare, sampled on the falling edge
  always @(negedge clock) begin : compareProc
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_valid", 64'(result_valid), 64'(e[3*N+3]));
      check("sb_carry", 64'(add_carry),    64'(e[3*N+2]));
      check("sb_borrow", 64'(sub_borrow),  64'(e[3*N+1]));
      check("sb_ovf",   64'(mul_overflow), 64'(e[3*N]));
      check("sb_add",   64'(addend),       64'(e[2*N +: N]));
      check("sb_diff",  64'(difference),   64'(e[N +: N]));
      check("sb_prod",  64'(product),      64'(e[0 +: N]));
    end
  end

  // driver tasks
  task automatic drive(input logic r, input logic en, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clock);
    reset = r; calculate_en = en; valueOne = a; valueTwo = b;
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [N-1:0] ad, input logic [N-1:0] df,
                            input logic [N-1:0] pr, input logic v, input logic c,
                            input logic bw, input logic o);
    check({tag, "_add"},    64'(addend),       64'(ad));
    check({tag, "_diff"},   64'(difference),   64'(df));
    check({tag, "_prod"},   64'(product),      64'(pr));
    check({tag, "_valid"},  64'(result_valid), 64'(v));
    check({tag, "_carry"},  64'(add_carry),    64'(c));
    check({tag, "_borrow"}, 64'(sub_borrow),   64'(bw));
    check({tag, "_ovf"},    64'(mul_overflow), 64'(o));
  endtask

  function automatic logic [N-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return N'($urandom_range(0, 15)) << FRAC;
      3:       return N'($urandom_range(0, 65535));
      default: return N'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("FAIL watchdog time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    logic [N-1:0] a, b;

    // reset held with enable and random operands
    drive(1'b1, 1'b1, N'($urandom), N'($urandom));
    after_edge();
    expect_all("reset", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // mixed fractions, A < B
    drive(1'b0, 1'b1, 32'h0003_0471, 32'h0010_104D);
    after_edge();
    expect_all("mixed", 32'h0013_14BE, 32'hFFF2_F424, 32'h0030_783F, 1'b1, 1'b0, 1'b1, 1'b0);

    // hold for 5 idle cycles with changing operands
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, N'($urandom), N'($urandom));
      after_edge();
      expect_all("hold", 32'h0013_14BE, 32'hFFF2_F424, 32'h0030_783F, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // 1.5 and 2.0
    drive(1'b0, 1'b1, 32'h0001_8000, 32'h0002_0000);
    after_edge();
    expect_all("onehalf", 32'h0003_8000, 32'hFFFF_8000, 32'h0003_0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // add wrap
    drive(1'b0, 1'b1, 32'hFFFF_0000, 32'h0002_0000);
    after_edge();
    check("carry_add",  64'(addend),    64'h0001_0000);
    check("carry_flag", 64'(add_carry), 64'd1);

    // multiply overflow: 256.0 * 256.0
    drive(1'b0, 1'b1, 32'h0100_0000, 32'h0100_0000);
    after_edge();
    expect_all("ovf", 32'h0200_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);

    // back-to-back enables, reset in the third cycle
    drive(1'b0, 1'b1, 32'h0000_0001, 32'h0000_0002);
    after_edge();
    expect_all("b2b0", 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h0004_0000, 32'h0000_8000);
    after_edge();
    expect_all("b2b1", 32'h0004_8000, 32'h0003_8000, 32'h0002_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0010);
    after_edge();
    expect_all("b2brst", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000);
    after_edge();
    expect_all("b2b3", '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // randomized vectors, scored by the model every cycle
    for (int i = 0; i < 10000; i++) begin
      a = pick_operand();
      b = ($urandom_range(0, 15) == 0) ? a : pick_operand();
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), a, b);
    end

    drive(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
